// File: rtl/sdram_seq.sv
// sdram_seq: command sequencer between one host request port and sdram_cmd.
// Runs the power-up init sequence, periodic auto refresh and closed-page
// single-beat reads/writes. tRAS/tRC are timed here; all other command
// spacing is signalled back by sdram_cmd through cmd_done.
// Optional feature macro: SDRAM_AUTO_PRECHARGE_EN (READ/WRITE with A10=1,
// explicit PRECHARGE state replaced by a tRP wait).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_ready never depends on req_valid. rsp_valid is a
// one-cycle pulse with no back-pressure. Each command is a one-cycle cmd_valid
// strobe with all cmd_* fields valid in that cycle; cmd_done is only looked at
// after the strobe cycle.
module sdram_seq #(
   parameter int CLK_FREQ = 100,
   parameter int RAW      = 12,
   parameter int CAW      = 8,
   parameter int DW       = 16,
   parameter int tRAS     = 37,
   parameter int tRC      = 60,
   parameter int tREF     = 64,
   parameter int tINIT    = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [2+RAW+CAW-1:0] req_addr,
   input  logic [DW-1:0]        req_wdata,
   input  logic [DW/8-1:0]      req_byteen,
   output logic                 rsp_valid,
   output logic [DW-1:0]        rsp_rdata,
   output logic                 init_done,
   input  logic [2:0]           cfg_cas_latency,
   output logic                 cmd_valid,
   output logic [3:0]           cmd_type,
   output logic [RAW-1:0]       cmd_addr,
   output logic [DW-1:0]        cmd_data,
   output logic [1:0]           cmd_ba,
   output logic [DW/8-1:0]      cmd_dqm,
   input  logic                 cmd_done,
   input  logic [DW-1:0]        sdram_dq_in
);

   // Command encodings {cs_n, ras_n, cas_n, we_n}, matching sdram_cmd.
   localparam logic [3:0] CMD_LMR       = 4'b0000;
   localparam logic [3:0] CMD_REFRESH   = 4'b0001;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_READ      = 4'b0101;

   localparam int C_RAS  = (tRAS * CLK_FREQ + 999) / 1000;
   localparam int C_RC   = (tRC * CLK_FREQ + 999) / 1000;
   localparam int C_INIT = tINIT * CLK_FREQ;
   localparam int C_REFI = (tREF * 1000 * CLK_FREQ) / (1 << RAW);

   localparam int INIT_W = $clog2(C_INIT + 1);
   localparam int RAS_W  = $clog2(C_RAS + 1);
   localparam int RC_W   = $clog2(C_RC + 1);
   localparam int REF_W  = $clog2(C_REFI + 1);

   localparam logic [RAW-1:0] A10 = RAW'(1024);

   typedef enum logic [3:0] {
      INIT_WAIT = 4'd0,
      INIT_PRE  = 4'd1,
      INIT_REF1 = 4'd2,
      INIT_REF2 = 4'd3,
      INIT_LMR  = 4'd4,
      IDLE      = 4'd5,
      ACT       = 4'd6,
      RW        = 4'd7,
      PRE       = 4'd8,
      REF       = 4'd9
`ifdef SDRAM_AUTO_PRECHARGE_EN
      , AP_WAIT = 4'd10
`endif
   } state_t;

   state_t state, next_state;

   // issued: the current command state has already strobed cmd_valid
   logic              issued;
   logic [INIT_W-1:0] init_cnt;
   logic [RAS_W-1:0]  ras_cnt;
   logic [RC_W-1:0]   rc_cnt;
   logic [REF_W-1:0]  ref_cnt;
   logic              ref_pending;
   logic              l_write;
   logic [1:0]        l_ba;
   logic [RAW-1:0]    l_row;
   logic [CAW-1:0]    l_col;
   logic [DW-1:0]     l_wdata;
   logic [DW/8-1:0]   l_byteen;
   logic              rd_busy;
   logic [2:0]        rd_cnt;

`ifdef SDRAM_AUTO_PRECHARGE_EN
   localparam int C_RP = (15 * CLK_FREQ + 999) / 1000;
   localparam int RP_W = $clog2(C_RP + 1);
   localparam logic [RAW-1:0] RW_A10 = A10;
   logic [RP_W-1:0] rp_cnt;

   // tRP wait after an auto-precharging access completes
   always_ff @(posedge clk) begin
      if (rst || state != AP_WAIT) rp_cnt <= '0;
      else                         rp_cnt <= rp_cnt + RP_W'(1);
   end
`else
   localparam logic [RAW-1:0] RW_A10 = '0;
`endif

   // State register plus per-state issue flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= INIT_WAIT;
         issued <= 1'b0;
      end else begin
         state  <= next_state;
         issued <= (next_state != state) ? 1'b0 : (issued | cmd_valid);
      end
   end

   // Next state and the command strobe with its fields
   always_comb begin
      next_state = state;
      cmd_valid  = 1'b0;
      cmd_type   = '0;
      cmd_addr   = '0;
      cmd_ba     = '0;
      cmd_data   = '0;
      cmd_dqm    = '0;
      req_ready  = 1'b0;
      case (state)
         INIT_WAIT: if (init_cnt == INIT_W'(C_INIT - 1)) next_state = INIT_PRE;
         INIT_PRE: begin
            if (!issued) begin
               cmd_valid = 1'b1; cmd_type = CMD_PRECHARGE; cmd_addr = A10;
            end else if (cmd_done) next_state = INIT_REF1;
         end
         INIT_REF1: begin
            if (!issued) begin
               cmd_valid = 1'b1; cmd_type = CMD_REFRESH;
            end else if (cmd_done) next_state = INIT_REF2;
         end
         INIT_REF2: begin
            if (!issued) begin
               cmd_valid = 1'b1; cmd_type = CMD_REFRESH;
            end else if (cmd_done) next_state = INIT_LMR;
         end
         INIT_LMR: begin
            // BL=1, sequential, burst write; only CAS latency varies
            if (!issued) begin
               cmd_valid = 1'b1; cmd_type = CMD_LMR;
               cmd_addr  = RAW'({cfg_cas_latency, 4'b0000});
            end else if (cmd_done) next_state = IDLE;
         end
         IDLE: begin
            req_ready = init_done & ~ref_pending;
            if (ref_pending)                 next_state = REF;
            else if (req_valid && req_ready) next_state = ACT;
         end
         ACT: begin
            if (!issued) begin
               if (rc_cnt == '0) begin
                  cmd_valid = 1'b1; cmd_type = CMD_ACTIVE;
                  cmd_ba    = l_ba; cmd_addr = l_row;
               end
            end else if (cmd_done) next_state = RW;
         end
         RW: begin
            if (!issued) begin
               cmd_valid = 1'b1;
               cmd_ba    = l_ba;
               cmd_addr  = RAW'(l_col) | RW_A10;
               if (l_write) begin
                  cmd_type = CMD_WRITE; cmd_data = l_wdata; cmd_dqm = ~l_byteen;
               end else begin
                  cmd_type = CMD_READ;
               end
            end else if (cmd_done) begin
`ifdef SDRAM_AUTO_PRECHARGE_EN
               next_state = AP_WAIT;
`else
               next_state = PRE;
`endif
            end
         end
         PRE: begin
            if (!issued) begin
               if (ras_cnt == '0) begin
                  cmd_valid = 1'b1; cmd_type = CMD_PRECHARGE; cmd_ba = l_ba;
               end
            end else if (cmd_done) next_state = IDLE;
         end
         REF: begin
            if (!issued) begin
               cmd_valid = 1'b1; cmd_type = CMD_REFRESH;
            end else if (cmd_done) next_state = IDLE;
         end
`ifdef SDRAM_AUTO_PRECHARGE_EN
         AP_WAIT: if (rp_cnt == RP_W'(C_RP - 1)) next_state = IDLE;
`endif
         default: next_state = INIT_WAIT;
      endcase
   end

   // Init wait, row timing counters, refresh timer and init_done flag
   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt    <= '0;
         ras_cnt     <= '0;
         rc_cnt      <= '0;
         ref_cnt     <= '0;
         ref_pending <= 1'b0;
         init_done   <= 1'b0;
      end else begin
         if (state == INIT_WAIT) init_cnt <= init_cnt + INIT_W'(1);
         if (state == ACT && cmd_valid) begin
            ras_cnt <= RAS_W'(C_RAS - 1);
            rc_cnt  <= RC_W'(C_RC - 1);
         end else begin
            if (ras_cnt != '0) ras_cnt <= ras_cnt - RAS_W'(1);
            if (rc_cnt != '0)  rc_cnt  <= rc_cnt - RC_W'(1);
         end
         if (state == REF && cmd_valid) ref_pending <= 1'b0;
         // An expiry while already pending just leaves the flag set
         if (init_done) begin
            if (ref_cnt == '0) begin
               ref_cnt     <= REF_W'(C_REFI - 1);
               ref_pending <= 1'b1;
            end else begin
               ref_cnt <= ref_cnt - REF_W'(1);
            end
         end
         if (state == INIT_LMR && issued && cmd_done) init_done <= 1'b1;
      end
   end

   // Request latch on the IDLE handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         l_write  <= 1'b0;
         l_ba     <= '0;
         l_row    <= '0;
         l_col    <= '0;
         l_wdata  <= '0;
         l_byteen <= '0;
      end else if (state == IDLE && next_state == ACT) begin
         l_write               <= req_write;
         {l_ba, l_row, l_col}  <= req_addr;
         l_wdata               <= req_wdata;
         l_byteen              <= req_byteen;
      end
   end

   // Read capture: READ in cycle T samples DQ at the end of T+CL+1
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_busy   <= 1'b0;
         rd_cnt    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (state == RW && cmd_valid && !l_write) begin
            rd_busy <= 1'b1;
            rd_cnt  <= cfg_cas_latency;
         end else if (rd_busy) begin
            if (rd_cnt == '0) begin
               rsp_rdata <= sdram_dq_in;
               rsp_valid <= 1'b1;
               rd_busy   <= 1'b0;
            end else begin
               rd_cnt <= rd_cnt - 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_seq.sv
// tb_sdram_seq: scoreboard bench for sdram_seq (tINIT=1 so init takes 100
// cycles). A small sdram_cmd/memory model drives cmd_done and sdram_dq_in.
module tb_sdram_seq;
   localparam int RAW = 12;
   localparam int CAW = 8;
   localparam int DW  = 16;
   localparam int AW  = 2 + RAW + CAW;
   localparam int CW  = 4 + 2 + RAW + DW + DW/8;

   localparam logic [3:0] CMD_LMR       = 4'b0000;
   localparam logic [3:0] CMD_REFRESH   = 4'b0001;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_READ      = 4'b0101;

`ifdef SDRAM_AUTO_PRECHARGE_EN
   localparam logic [RAW-1:0] RW_A10 = 12'h400;
`else
   localparam logic [RAW-1:0] RW_A10 = 12'h000;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, req_write;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_byteen;
   logic            rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            init_done;
   logic [2:0]      cfg_cas_latency;
   logic            cmd_valid;
   logic [3:0]      cmd_type;
   logic [RAW-1:0]  cmd_addr;
   logic [DW-1:0]   cmd_data;
   logic [1:0]      cmd_ba;
   logic [DW/8-1:0] cmd_dqm;
   logic            cmd_done;
   logic [DW-1:0]   sdram_dq_in;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [CW-1:0] exp_cmd_q[$];
   logic [DW-1:0] exp_q[$];

   // model / monitor bookkeeping
   int done_cnt = 0;
   int act_delay = 0;
   int dq_cyc = -100;
   logic [DW-1:0] mem_rdata = '0;
   int last_act = -1;
   int act_seen = 0;
   int rd_issue = 0;
   int rd_cl = 0;
   int pre_all_cyc = -1;
   int lmr_cyc = -1;
   int rsp_seen = 0;
   int ref_cycs[$];
   logic ready_pre_init = 1'b0;

   sdram_seq #(.tINIT(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
      .cfg_cas_latency(cfg_cas_latency),
      .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_ba(cmd_ba), .cmd_dqm(cmd_dqm),
      .cmd_done(cmd_done), .sdram_dq_in(sdram_dq_in)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [CW-1:0] mk_cmd(input logic [3:0] t, input logic [1:0] ba,
                                            input logic [RAW-1:0] a, input logic [DW-1:0] d,
                                            input logic [DW/8-1:0] m);
      return {t, ba, a, d, m};
   endfunction

   // sdram_cmd model: cmd_done stays high while idle (so it is already high
   // in the issue cycle); READ completes CL+2 cycles after issue
   always @(posedge clk) begin
      if (rst) done_cnt <= 0;
      else if (cmd_valid) begin
         if (cmd_type == CMD_READ)        done_cnt <= int'(cfg_cas_latency) + 1;
         else if (cmd_type == CMD_ACTIVE) done_cnt <= act_delay;
         else                             done_cnt <= 0;
      end else if (done_cnt > 0) done_cnt <= done_cnt - 1;
   end
   assign cmd_done = (done_cnt == 0);

   // memory model: valid read data only in cycle T+CL+1
   always @(posedge clk) begin
      #1;
      sdram_dq_in = (cyc == dq_cyc) ? mem_rdata : 16'h0BAD;
   end

   // monitor: pops expected commands and responses as the DUT presents them
   always @(negedge clk) begin
      if (!rst) begin
         if (!init_done && req_ready) ready_pre_init = 1'b1;
         if (cmd_valid) begin
            if (exp_cmd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_cmd: got type %0h ba %0h addr %0h, required no command (cycle %0d)",
                        cmd_type, cmd_ba, cmd_addr, cyc);
            end else begin
               check("cmd", {cmd_type, cmd_ba, cmd_addr, cmd_data, cmd_dqm}, exp_cmd_q.pop_front());
            end
            case (cmd_type)
               CMD_ACTIVE: begin
                  if (last_act >= 0) check("trc_spacing_ok", 64'(cyc - last_act >= 6), 64'd1);
                  last_act = cyc;
                  act_seen++;
               end
               CMD_PRECHARGE: begin
                  if (cmd_addr[10]) pre_all_cyc = cyc;
                  else check("tras_spacing_ok", 64'(cyc - last_act >= 4), 64'd1);
               end
               CMD_READ: begin
                  rd_issue = cyc;
                  rd_cl    = int'(cfg_cas_latency);
                  dq_cyc   = cyc + rd_cl + 1;
               end
               CMD_REFRESH: if (init_done) ref_cycs.push_back(cyc);
               CMD_LMR: lmr_cyc = cyc;
               default: ;
            endcase
         end
         if (rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rsp: got %0h, required no response (cycle %0d)", rsp_rdata, cyc);
            end else begin
               check("rsp_rdata", rsp_rdata, exp_q.pop_front());
               check("rsp_latency", cyc - rd_issue, rd_cl + 2);
            end
         end
      end
   end

   // driver: present a request until accepted, push its expected traffic
   task automatic do_req(input logic wr, input logic [1:0] ba, input logic [RAW-1:0] row,
                         input logic [CAW-1:0] col, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] be, output int acc, output logic ready_first);
      req_valid = 1'b1; req_write = wr; req_addr = {ba, row, col};
      req_wdata = wd; req_byteen = be;
      acc = -1; ready_first = 1'b0;
      for (int i = 0; i < 300 && acc < 0; i++) begin
         @(negedge clk);
         if (i == 0) ready_first = req_ready;
         if (req_ready) begin
            acc = cyc;
            exp_cmd_q.push_back(mk_cmd(CMD_ACTIVE, ba, row, '0, '0));
            if (wr) exp_cmd_q.push_back(mk_cmd(CMD_WRITE, ba, RAW'(col) | RW_A10, wd, ~be));
            else begin
               exp_cmd_q.push_back(mk_cmd(CMD_READ, ba, RAW'(col) | RW_A10, '0, '0));
               exp_q.push_back(mem_rdata);
            end
`ifndef SDRAM_AUTO_PRECHARGE_EN
            exp_cmd_q.push_back(mk_cmd(CMD_PRECHARGE, ba, '0, '0, '0));
`endif
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (acc < 0) begin
         checks++; failures++;
         $display("FAIL req_accept_timeout: req_ready stayed 0, required 1 within 300 cycles");
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_cmd_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
         @(negedge clk); n++;
      end
      if (n >= 400) begin
         checks++; failures++;
         $display("FAIL %s_timeout: %0d cmds and %0d rsps outstanding, required 0",
                  name, exp_cmd_q.size(), exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int c0, init_cyc, acc, n, a0, rsp_base;
      logic rf;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_byteen = '0; cfg_cas_latency = 3'd3;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_outputs", {cmd_valid, req_ready, rsp_valid, init_done, cmd_type, cmd_addr,
                              cmd_data, cmd_ba, cmd_dqm, rsp_rdata}, 64'd0);
      check("reset_state", 64'(dut.state), 64'd0);

      // init: PRECHARGE all, REFRESH x2, LMR CL=3, then the first timer REFRESH
      exp_cmd_q.push_back(mk_cmd(CMD_PRECHARGE, 2'd0, 12'h400, '0, '0));
      exp_cmd_q.push_back(mk_cmd(CMD_REFRESH, 2'd0, '0, '0, '0));
      exp_cmd_q.push_back(mk_cmd(CMD_REFRESH, 2'd0, '0, '0, '0));
      exp_cmd_q.push_back(mk_cmd(CMD_LMR, 2'd0, 12'h030, '0, '0));
      exp_cmd_q.push_back(mk_cmd(CMD_REFRESH, 2'd0, '0, '0, '0));
      @(posedge clk); #1;
      rst = 1'b0; c0 = cyc;
      n = 0;
      while (!init_done && n < 400) begin @(negedge clk); n++; end
      if (!init_done) begin
         checks++; failures++;
         $display("FAIL init_timeout: init_done=0, required 1 within 400 cycles");
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
      init_cyc = cyc;
      check("init_pre_cycle", pre_all_cyc, c0 + 100);
      check("init_done_cycle", init_cyc, lmr_cyc + 2);
      check("ready_low_during_init", ready_pre_init, 1'b0);

      // refresh pending meets a request: REFRESH first, then the write
      @(posedge clk); #1;
      do_req(1'b1, 2'd1, 12'h123, 8'h45, 16'hA5A5, 2'b01, acc, rf);
      check("ready_blocked_by_ref", rf, 1'b0);
      check("req_after_ref", 64'(ref_cycs.size() > 0 && acc > ref_cycs[0]), 64'd1);
      wait_drain("write1");

      // read CL=2
      cfg_cas_latency = 3'd2; mem_rdata = 16'h5A5A;
      do_req(1'b0, 2'd1, 12'h123, 8'h45, '0, '0, acc, rf);
      wait_drain("read_cl2");

      // back-to-back same bank: write then read CL=3, all-ones row/col
      cfg_cas_latency = 3'd3; mem_rdata = 16'h1234;
      do_req(1'b1, 2'd2, 12'hFFF, 8'hFF, 16'hBEEF, 2'b10, acc, rf);
      do_req(1'b0, 2'd2, 12'hFFF, 8'hFF, '0, '0, acc, rf);
      do_req(1'b1, 2'd3, 12'h000, 8'h00, 16'hFFFF, 2'b11, acc, rf);
      wait_drain("b2b");

      // second timer REFRESH comes cREFI=1562 cycles after the first
      exp_cmd_q.push_back(mk_cmd(CMD_REFRESH, 2'd0, '0, '0, '0));
      n = 0;
      while (ref_cycs.size() < 2 && n < 2000) begin @(negedge clk); n++; end
      if (ref_cycs.size() < 2) begin
         checks++; failures++;
         $display("FAIL refresh_timeout: %0d refreshes seen, required 2", ref_cycs.size());
      end else begin
         check("refresh_period", ref_cycs[1] - ref_cycs[0], 1562);
      end
      @(posedge clk); #1;

      // reset during a read's ACT wait
      act_delay = 5; mem_rdata = 16'h7777;
      a0 = act_seen;
      do_req(1'b0, 2'd0, 12'h055, 8'h10, '0, '0, acc, rf);
      n = 0;
      while (act_seen == a0 && n < 50) begin @(negedge clk); n++; end
      check("act_before_reset", 64'(act_seen > a0), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_cmd_q.delete();
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      check("midreset_outputs", {cmd_valid, req_ready, rsp_valid, init_done, cmd_type, cmd_addr,
                                 cmd_data, cmd_ba, cmd_dqm, rsp_rdata}, 64'd0);
      check("midreset_state", 64'(dut.state), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; rsp_base = rsp_seen;
      repeat (40) @(negedge clk);
      check("no_rsp_after_reset", rsp_seen - rsp_base, 0);
      check("init_done_after_reset", init_done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
